dreq_unit: RTL and testbench

DREQ_UNIT -- requirements
Module: dreq_unit

---
 rtl/dreq_unit_if.sv | 33 +++
 rtl/dreq_unit.sv | 114 +++++++++++
 tb/tb_dreq_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dreq_unit_if.sv
// Pipeline/cache request bundle for dreq_unit.
// master = pipeline + cache side, slave = the request unit.
interface dreq_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_ren;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              advance;
    logic              flush;
    logic              dhit;
    logic [DATA_W-1:0] dmemload;
    logic              dmemREN;
    logic              dmemWEN;
    logic [ADDR_W-1:0] dmemaddr;
    logic [DATA_W-1:0] dmemstore;
    logic              stall;
    logic [DATA_W-1:0] rdata;
    logic              done;
    logic              timeout_err;

    modport master (
        output req_ren, req_wen, req_addr, req_wdata, advance, flush, dhit, dmemload,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, stall, rdata, done, timeout_err
    );

    modport slave (
        input  req_ren, req_wen, req_addr, req_wdata, advance, flush, dhit, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, stall, rdata, done, timeout_err
    );
endinterface

// File: rtl/dreq_unit.sv
// Memory-stage data request unit: issues one cache transaction per request,
// holds the pipeline while it is outstanding, and bounds the wait with a timeout.
//
// state | meaning
// IDLE  | no transaction; a request (not flushed) is accepted on the next edge
// BUSY  | cache enable asserted, waiting for dhit or timeout
// DONE  | transaction finished, waiting for advance/flush before a new request
module dreq_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic       CLK,
    input  logic       nRST,
    dreq_unit_if.slave bus
);
    localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_is_wr;
    logic              r_flushed;
    logic              r_ren;
    logic              r_wen;
    logic              r_done;
    logic              r_terr;

    logic w_req;
    logic w_accept;
    logic w_to_hit;
    logic w_busy_end;
    logic w_flushed;
    logic w_next_wr;
    logic w_stall;

    assign w_req      = bus.req_ren | bus.req_wen;
    assign w_accept   = (r_state == ST_IDLE) && w_req && !bus.flush;
    assign w_to_hit   = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
    assign w_busy_end = (r_state == ST_BUSY) && (bus.dhit || w_to_hit);
    // A flush arriving in the final BUSY cycle still suppresses completion.
    assign w_flushed  = r_flushed | bus.flush;
    assign w_next_wr  = w_accept ? bus.req_wen : r_is_wr;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_BUSY;
            ST_BUSY: if (w_busy_end) w_next = w_flushed ? ST_IDLE : ST_DONE;
            ST_DONE: if (bus.advance || bus.flush) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_stall = 1'b0;
        if (w_accept || (r_state == ST_BUSY)) w_stall = 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_cnt     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_is_wr   <= 1'b0;
            r_flushed <= 1'b0;
            r_ren     <= 1'b0;
            r_wen     <= 1'b0;
            r_done    <= 1'b0;
            r_terr    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr    <= bus.req_addr;
                r_wdata   <= bus.req_wdata;
                r_is_wr   <= bus.req_wen;
                r_cnt     <= '0;
                r_flushed <= 1'b0;
            end else if (r_state == ST_BUSY) begin
                if (bus.flush) r_flushed <= 1'b1;
                if (!bus.dhit && (r_cnt != CNT_MAX)) r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_busy_end && bus.dhit && !w_flushed && !r_is_wr) r_rdata <= bus.dmemload;
            if ((r_state == ST_BUSY) && !bus.dhit && w_to_hit) r_terr <= 1'b1;
            r_done <= w_busy_end && !w_flushed;
            r_ren  <= (w_next == ST_BUSY) && !w_next_wr;
            r_wen  <= (w_next == ST_BUSY) && w_next_wr;
        end
    end

    assign bus.dmemREN     = r_ren;
    assign bus.dmemWEN     = r_wen;
    assign bus.dmemaddr    = r_addr;
    assign bus.dmemstore   = r_wdata;
    assign bus.stall       = w_stall;
    assign bus.rdata       = r_rdata;
    assign bus.done        = r_done;
    assign bus.timeout_err = r_terr;
endmodule

// File: tb/tb_dreq_unit.sv
// Directed bench for dreq_unit: per-cycle vector table plus timeout and reset sequences.
module tb_dreq_unit;
    logic CLK;
    logic nRST;
    int   total = 0;
    int   bad   = 0;

    dreq_unit_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    dreq_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(8)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] ren, wen, addr, wdata, adv, flush, dhit, dload;
        logic [31:0] e_ren, e_wen, e_stall, e_done, e_terr, e_rdata, e_addr, e_store;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [31:0] ren, wen, addr, wdata, adv, flush, dhit, dload,
                       input logic [31:0] e_ren, e_wen, e_stall, e_done, e_terr,
                       input logic [31:0] e_rdata, e_addr, e_store);
        vec_t v;
        v.ren = ren; v.wen = wen; v.addr = addr; v.wdata = wdata;
        v.adv = adv; v.flush = flush; v.dhit = dhit; v.dload = dload;
        v.e_ren = e_ren; v.e_wen = e_wen; v.e_stall = e_stall; v.e_done = e_done;
        v.e_terr = e_terr; v.e_rdata = e_rdata; v.e_addr = e_addr; v.e_store = e_store;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ren, wen, input logic [31:0] addr, wdata,
                         input logic adv, flush, dhit, input logic [31:0] dload);
        bus.req_ren = ren; bus.req_wen = wen; bus.req_addr = addr; bus.req_wdata = wdata;
        bus.advance = adv; bus.flush = flush; bus.dhit = dhit; bus.dmemload = dload;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1, "watchdog expired");
    end

    localparam logic [31:0] DB = 32'hDEADBEEF;

    initial begin
        int n_ren;
        int got_done;

        // read, dhit on 3rd BUSY cycle
        add(1,0,'h100,0,0,0,0,0,          0,0,1,0,0, 0,0,0);
        add(1,0,'h100,0,0,0,0,0,          1,0,1,0,0, 0,'h100,0);
        add(1,0,'h100,0,0,0,0,0,          1,0,1,0,0, 0,'h100,0);
        add(1,0,'h100,0,0,0,1,DB,         1,0,1,0,0, 0,'h100,0);
        add(1,0,'h100,0,1,0,0,0,          0,0,0,1,0, DB,'h100,0);
        add(0,0,0,0,0,0,0,0,              0,0,0,0,0, DB,'h100,0);
        // write, immediate dhit, advance held off 4 DONE cycles
        add(0,1,'h200,'h55,0,0,0,0,       0,0,1,0,0, DB,'h100,0);
        add(0,1,'h200,'h55,0,0,1,'h99,    0,1,1,0,0, DB,'h200,'h55);
        add(0,1,'h200,'h55,0,0,0,0,       0,0,0,1,0, DB,'h200,'h55);
        add(0,1,'h200,'h55,0,0,0,0,       0,0,0,0,0, DB,'h200,'h55);
        add(0,1,'h200,'h55,0,0,0,0,       0,0,0,0,0, DB,'h200,'h55);
        add(0,1,'h200,'h55,1,0,0,0,       0,0,0,0,0, DB,'h200,'h55);
        // read+write conflict is a write; dmemload ignored
        add(1,1,'h300,'hA5,0,0,0,0,       0,0,1,0,0, DB,'h200,'h55);
        add(1,1,'h300,'hA5,0,0,0,0,       0,1,1,0,0, DB,'h300,'hA5);
        add(1,1,'h300,'hA5,0,0,1,'h12345678, 0,1,1,0,0, DB,'h300,'hA5);
        add(1,1,'h300,'hA5,1,0,0,0,       0,0,0,1,0, DB,'h300,'hA5);
        // stray dhit in IDLE
        add(0,0,0,0,0,0,1,'h11111111,     0,0,0,0,0, DB,'h300,'hA5);
        add(0,0,0,0,0,0,0,0,              0,0,0,0,0, DB,'h300,'hA5);
        // flush mid-BUSY, dhit two cycles later
        add(1,0,'h400,0,0,0,0,0,          0,0,1,0,0, DB,'h300,'hA5);
        add(1,0,'h400,0,0,1,0,0,          1,0,1,0,0, DB,'h400,0);
        add(1,0,'h400,0,0,0,0,0,          1,0,1,0,0, DB,'h400,0);
        add(1,0,'h400,0,0,0,1,'hCAFEF00D, 1,0,1,0,0, DB,'h400,0);
        add(0,0,0,0,0,0,0,0,              0,0,0,0,0, DB,'h400,0);
        add(0,0,0,0,0,0,0,0,              0,0,0,0,0, DB,'h400,0);
        // request with flush in IDLE is not accepted
        add(1,0,'h700,0,0,1,0,0,          0,0,0,0,0, DB,'h400,0);
        add(0,0,0,0,0,0,0,0,              0,0,0,0,0, DB,'h400,0);

        nRST = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_ren",   64'(bus.dmemREN), 64'(0));
        chk("rst_wen",   64'(bus.dmemWEN), 64'(0));
        chk("rst_stall", 64'(bus.stall), 64'(0));
        chk("rst_rdata", 64'(bus.rdata), 64'(0));
        chk("rst_terr",  64'(bus.timeout_err), 64'(0));
        nRST = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            drive(vecs[i].ren[0], vecs[i].wen[0], vecs[i].addr, vecs[i].wdata,
                  vecs[i].adv[0], vecs[i].flush[0], vecs[i].dhit[0], vecs[i].dload);
            #1;
            chk($sformatf("v%0d_ren", i),   64'(bus.dmemREN),     64'(vecs[i].e_ren));
            chk($sformatf("v%0d_wen", i),   64'(bus.dmemWEN),     64'(vecs[i].e_wen));
            chk($sformatf("v%0d_stall", i), 64'(bus.stall),       64'(vecs[i].e_stall));
            chk($sformatf("v%0d_done", i),  64'(bus.done),        64'(vecs[i].e_done));
            chk($sformatf("v%0d_terr", i),  64'(bus.timeout_err), 64'(vecs[i].e_terr));
            chk($sformatf("v%0d_rdata", i), 64'(bus.rdata),       64'(vecs[i].e_rdata));
            chk($sformatf("v%0d_addr", i),  64'(bus.dmemaddr),    64'(vecs[i].e_addr));
            chk($sformatf("v%0d_store", i), 64'(bus.dmemstore),   64'(vecs[i].e_store));
        end

        // dhit in the last counted BUSY cycle completes normally
        @(negedge CLK);
        drive(1, 0, 'h580, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            drive(1, 0, 'h580, 0, 0, 0, (i == 7), 32'h0BADF00D);
            #1;
            chk($sformatf("hitwin_ren%0d", i), 64'(bus.dmemREN), 64'(1));
        end
        @(negedge CLK);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        #1;
        chk("hitwin_done",  64'(bus.done), 64'(1));
        chk("hitwin_terr",  64'(bus.timeout_err), 64'(0));
        chk("hitwin_rdata", 64'(bus.rdata), 64'(32'h0BADF00D));

        // timeout: no dhit for TIMEOUT=8 cycles
        @(negedge CLK);
        drive(1, 0, 'h500, 0, 0, 0, 0, 32'hBAD0BAD0);
        #1;
        chk("to_stall_req", 64'(bus.stall), 64'(1));
        @(negedge CLK);
        #1;
        n_ren = 0;
        got_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin
                got_done = 1;
                break;
            end
            if (bus.dmemREN) n_ren++;
            @(negedge CLK);
            #1;
        end
        chk("to_done_seen", 64'(got_done), 64'(1));
        chk("to_ren_cycles", 64'(n_ren), 64'(8));
        chk("to_terr",  64'(bus.timeout_err), 64'(1));
        chk("to_rdata", 64'(bus.rdata), 64'(32'h0BADF00D));
        chk("to_stall_done", 64'(bus.stall), 64'(0));
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        @(negedge CLK);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("to_done_pulse", 64'(bus.done), 64'(0));
        chk("to_terr_sticky", 64'(bus.timeout_err), 64'(1));

        // async reset mid-BUSY
        @(negedge CLK);
        drive(1, 0, 'h600, 'h77, 0, 0, 0, 0);
        @(negedge CLK);
        @(negedge CLK);
        #1;
        chk("pre_rst_ren", 64'(bus.dmemREN), 64'(1));
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        nRST = 1'b0;
        #1;
        chk("arst_ren",   64'(bus.dmemREN), 64'(0));
        chk("arst_wen",   64'(bus.dmemWEN), 64'(0));
        chk("arst_addr",  64'(bus.dmemaddr), 64'(0));
        chk("arst_store", 64'(bus.dmemstore), 64'(0));
        chk("arst_rdata", 64'(bus.rdata), 64'(0));
        chk("arst_done",  64'(bus.done), 64'(0));
        chk("arst_terr",  64'(bus.timeout_err), 64'(0));
        chk("arst_stall", 64'(bus.stall), 64'(0));
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        #1;
        chk("post_rst_ren",   64'(bus.dmemREN), 64'(0));
        chk("post_rst_stall", 64'(bus.stall), 64'(0));

        // request accepted on the first edge after reset release
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        nRST = 1'b1;
        drive(1, 0, 'h800, 0, 0, 0, 0, 0);
        @(negedge CLK);
        #1;
        chk("first_edge_ren",  64'(bus.dmemREN), 64'(1));
        chk("first_edge_addr", 64'(bus.dmemaddr), 64'(32'h800));
        drive(1, 0, 'h800, 0, 0, 0, 1, 32'h600DD00D);
        @(negedge CLK);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        #1;
        chk("first_edge_done",  64'(bus.done), 64'(1));
        chk("first_edge_rdata", 64'(bus.rdata), 64'(32'h600DD00D));
        @(negedge CLK);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
